// File: rtl/lenet_quant_pkg.sv
// lenet_quant_pkg: shared widths, clamp-mode encodings and clamp-bound helpers for the requantizer
package lenet_quant_pkg;
  localparam int IN_W_D    = 23;
  localparam int OUT_W_D   = 8;
  localparam int LANES_D   = 4;
  localparam int SHIFT_W_D = 5;
  localparam int CNT_W     = 16;
  typedef enum logic {MODE_SIGNED = 1'b0, MODE_RELU = 1'b1} mode_e;
  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_lo(input int w, input mode_e m);
    return (m == MODE_RELU) ? 0 : -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/lenet_requant_if.sv
// lenet_requant_if: input/output beat streams of the requantizer
//   in_valid/in_ready/in_data    : accumulator beats, lane i at [i*IN_W +: IN_W]
//   out_valid/out_ready/out_data : quantized beats, lane i at [i*OUT_W +: OUT_W]
//   master = upstream/downstream side, slave = requantizer
interface lenet_requant_if #(
  parameter int IN_W  = lenet_quant_pkg::IN_W_D,
  parameter int OUT_W = lenet_quant_pkg::OUT_W_D,
  parameter int LANES = lenet_quant_pkg::LANES_D
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/requant_lane.sv
// requant_lane: one lane, stage 1 rounds half-up and shifts, stage 2 clamps to OUT_W
//   i_x     : signed accumulator value      i_shift : right-shift amount
//   i_relu  : clamp mode for this beat      i_en    : pipeline enable
//   o_out   : registered clamped value      o_sat   : stage-1 value saturates on its way to stage 2
module requant_lane import lenet_quant_pkg::*; #(
  parameter int IN_W    = IN_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int SHIFT_W = SHIFT_W_D
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               i_en,
  input  logic [IN_W-1:0]    i_x,
  input  logic [SHIFT_W-1:0] i_shift,
  input  mode_e              i_relu,
  output logic [OUT_W-1:0]   o_out,
  output logic               o_sat
);
  localparam logic signed [IN_W:0] HI   = (IN_W + 1)'(sat_hi(OUT_W));
  localparam logic signed [IN_W:0] LO_S = (IN_W + 1)'(sat_lo(OUT_W, MODE_SIGNED));
  logic signed [IN_W:0] w_rnd, w_s, w_lo, r_s;
  logic                 w_hi_sat, w_lo_sat;
  logic [OUT_W-1:0]     w_out, r_out;
  mode_e                r_relu;
  // one extra bit of headroom so x + 2^(shift-1) never wraps
  always_comb begin
    w_rnd    = (i_shift == '0) ? '0 : (IN_W + 1)'(1) << (i_shift - 1'b1);
    w_s      = ($signed({i_x[IN_W-1], i_x}) + w_rnd) >>> i_shift;
    w_lo     = (r_relu == MODE_RELU) ? '0 : LO_S;
    w_hi_sat = r_s > HI;
    w_lo_sat = r_s < w_lo;
    w_out    = w_hi_sat ? HI[OUT_W-1:0] : w_lo_sat ? w_lo[OUT_W-1:0] : r_s[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_s    <= '0;
      r_relu <= MODE_SIGNED;
      r_out  <= '0;
    end else if (i_en) begin
      r_s    <= w_s;
      r_relu <= i_relu;
      r_out  <= w_out;
    end
  end
  assign o_out = r_out;
  assign o_sat = w_hi_sat | w_lo_sat;
endmodule

// File: rtl/lenet_requant.sv
// lenet_requant: multi-lane round/shift/saturate requantizer, 2-stage valid/ready pipeline
//   s_if       : beat streams (slave side)
//   i_cfg_*    : shift/relu config request, honoured only when idle; o_cfg_err sticky on reject
//   o_busy     : a pipeline stage holds a beat
//   i_sat_clr  : clear saturation counter     o_sat_cnt : saturated-lane count
//   LENET_REQ_SAT_CNT_EN enables the saturation counter; otherwise o_sat_cnt is 0
module lenet_requant import lenet_quant_pkg::*; #(
  parameter int IN_W      = IN_W_D,
  parameter int OUT_W     = OUT_W_D,
  parameter int LANES     = LANES_D,
  parameter int SHIFT_W   = SHIFT_W_D,
  parameter int RST_SHIFT = 6,
  parameter bit RST_RELU  = 1'b1
) (
  input  logic               clk,
  input  logic               srstn,
  lenet_requant_if.slave     s_if,
  input  logic               i_cfg_load,
  input  logic [SHIFT_W-1:0] i_cfg_shift,
  input  logic               i_cfg_relu,
  output logic               o_cfg_err,
  output logic               o_busy,
  input  logic               i_sat_clr,
  output logic [CNT_W-1:0]   o_sat_cnt
);
  logic                   w_en, w_acc, w_cfg_ok, r_v1, r_out_valid, r_cfg_err;
  logic [SHIFT_W-1:0]     w_cfg_shift, r_shift;
  mode_e                  r_mode;
  logic [LANES-1:0]       w_sat;
  logic [LANES*OUT_W-1:0] w_out_data;
  assign w_en        = ~r_out_valid | s_if.out_ready;
  assign w_acc       = s_if.in_valid & w_en;
  assign w_cfg_ok    = i_cfg_load & ~o_busy & ~s_if.in_valid;
  assign w_cfg_shift = (int'(i_cfg_shift) >= IN_W) ? SHIFT_W'(IN_W - 1) : i_cfg_shift;
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_shift     <= SHIFT_W'(RST_SHIFT);
      r_mode      <= mode_e'(RST_RELU);
    end else begin
      if (w_en) begin
        r_v1        <= w_acc;
        r_out_valid <= r_v1;
      end
      if (w_cfg_ok) begin
        r_shift <= w_cfg_shift;
        r_mode  <= mode_e'(i_cfg_relu);
      end else if (i_cfg_load) begin
        r_cfg_err <= 1'b1;
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_lane (
      .clk    (clk),
      .srstn  (srstn),
      .i_en   (w_en),
      .i_x    (s_if.in_data[i*IN_W +: IN_W]),
      .i_shift(r_shift),
      .i_relu (r_mode),
      .o_out  (w_out_data[i*OUT_W +: OUT_W]),
      .o_sat  (w_sat[i])
    );
  end
  assign s_if.in_ready  = w_en;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = w_out_data;
  assign o_busy         = r_v1 | r_out_valid;
  assign o_cfg_err      = r_cfg_err;
`ifdef LENET_REQ_SAT_CNT_EN
  logic [CNT_W-1:0] r_sat_cnt, w_add;
  logic [CNT_W:0]   w_sum;
  // lanes count only when a valid beat actually moves into stage 2
  always_comb begin
    w_add = '0;
    for (int i = 0; i < LANES; i++) w_add = w_add + CNT_W'(w_sat[i] & r_v1 & w_en);
    w_sum = {1'b0, r_sat_cnt} + {1'b0, w_add};
  end
  always_ff @(posedge clk) begin
    if (!srstn || i_sat_clr) r_sat_cnt <= '0;
    else r_sat_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end
  assign o_sat_cnt = r_sat_cnt;
`else
  logic w_unused;
  assign w_unused  = ^{i_sat_clr, w_sat};
  assign o_sat_cnt = '0;
`endif
endmodule

// File: tb/tb_lenet_requant.sv
// tb_lenet_requant: directed self-checking bench for lenet_requant
module tb_lenet_requant;
`ifdef LENET_REQ_SAT_CNT_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif
  logic        clk, srstn, cfg_load, cfg_relu, cfg_err, busy, sat_clr;
  logic [4:0]  cfg_shift;
  logic [15:0] sat_cnt;
  int          checks = 0, errors = 0, k = 0;
  lenet_requant_if bus ();
  lenet_requant dut (
    .clk        (clk),
    .srstn      (srstn),
    .s_if       (bus),
    .i_cfg_load (cfg_load),
    .i_cfg_shift(cfg_shift),
    .i_cfg_relu (cfg_relu),
    .o_cfg_err  (cfg_err),
    .o_busy     (busy),
    .i_sat_clr  (sat_clr),
    .o_sat_cnt  (sat_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [91:0] pin(input int a, input int b, input int c, input int d);
    return {d[22:0], c[22:0], b[22:0], a[22:0]};
  endfunction
  function automatic logic [31:0] pout(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction
  function automatic logic [91:0] beat(input int n);
    return pin(32 * (n + 1), -32 * (n + 1), 0, 64 * (n + 1));
  endfunction
  function automatic logic [31:0] bexp(input int n);
    return pout(n + 1, -(n + 1), 0, 2 * (n + 1));
  endfunction
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_tick();
    logic acc;
    #1;
    acc = bus.in_valid & bus.in_ready;
    tick();
    if (acc) begin
      k++;
      if (k < 5) bus.in_data = beat(k);
      else bus.in_valid = 1'b0;
    end
  endtask
  task automatic cfg(input logic [4:0] sh, input logic rl);
    cfg_load = 1'b1; cfg_shift = sh; cfg_relu = rl;
    tick();
    cfg_load = 1'b0;
  endtask
  task automatic run_beat(input string tag, input logic [91:0] d, input logic [31:0] e);
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, bus.out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_data"}, bus.out_data, e);
    tick();
  endtask
  initial begin
    srstn = 1'b0; cfg_load = 1'b0; cfg_shift = '0; cfg_relu = 1'b0; sat_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sat_cnt", sat_cnt, 16'h0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    srstn = 1'b1;
    tick();
    // reset config: shift 6, ReLU
    run_beat("t1", pin(100, -500, 8160, 8127), pout(2, 0, 127, 127));
    chk("t1_sat_cnt", sat_cnt, 16'(SE * 2));
    chk("t1_idle", busy, 1'b0);
    // shift 5, signed
    cfg(5'd5, 1'b0);
    chk("t2_cfg_err", cfg_err, 1'b0);
    run_beat("t2", pin(-4112, -4113, 4079, 4080), pout(-128, -128, 127, 127));
    chk("t2_sat_cnt", sat_cnt, 16'(SE * 4));
    // backpressure: five stalled cycles with continuous input
    bus.out_ready = 1'b0; k = 0; bus.in_valid = 1'b1; bus.in_data = beat(0);
    for (int c = 0; c < 5; c++) begin
      send_tick();
      if (c > 0) begin
        chk("t3_stall_valid", bus.out_valid, 1'b1);
        chk("t3_stall_data", bus.out_data, bexp(0));
      end
    end
    chk("t3_in_ready_low", bus.in_ready, 1'b0);
    chk("t3_accepted", k, 2);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t3_drain_valid", bus.out_valid, 1'b1);
      chk("t3_drain_data", bus.out_data, bexp(j));
      send_tick();
    end
    chk("t3_drained", bus.out_valid, 1'b0);
    chk("t3_all_in", k, 5);
    chk("t3_sat_cnt", sat_cnt, 16'(SE * 4));
    tick();
    // config request while busy is rejected
    bus.in_valid = 1'b1; bus.in_data = pin(100, -100, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_busy", busy, 1'b1);
    cfg(5'd3, 1'b1);
    chk("t4_cfg_err", cfg_err, 1'b1);
    chk("t4_a_data", bus.out_data, pout(3, -3, 0, 0));
    tick();
    run_beat("t4b", pin(-4112, -4113, 4079, 4080), pout(-128, -128, 127, 127));
    chk("t4_sat_cnt", sat_cnt, 16'(SE * 6));
    chk("t4_err_sticky", cfg_err, 1'b1);
    // out-of-range shift clamps to 22; extreme inputs do not overflow
    cfg(5'd31, 1'b0);
    run_beat("t5_s22", pin(-4194304, 0, 0, 4194303), pout(-1, 0, 0, 1));
    cfg(5'd22, 1'b0);
    run_beat("t5_s22b", pin(-4194304, -1, 4194303, 2097151), pout(-1, 0, 1, 0));
    cfg(5'd0, 1'b0);
    run_beat("t5_s0", pin(5, -5, 200, -200), pout(5, -5, 127, -128));
    chk("t5_sat_cnt", sat_cnt, 16'(SE * 8));
    // sat_clr wins over a coincident increment
    bus.in_valid = 1'b1; bus.in_data = pin(200, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("t6_clr_cnt", sat_cnt, 16'h0);
    chk("t6_clr_data", bus.out_data, pout(127, 0, 0, 0));
    tick();
    run_beat("t6_post", pin(200, 0, 0, 0), pout(127, 0, 0, 0));
    chk("t6_post_cnt", sat_cnt, 16'(SE * 1));
    // reset mid-stream
    bus.in_valid = 1'b1; bus.in_data = pin(64, 64, 64, 64);
    tick(); tick();
    chk("t6_pre_rst_valid", bus.out_valid, 1'b1);
    srstn = 1'b0;
    tick();
    srstn = 1'b1; bus.in_valid = 1'b0;
    chk("t6_rst_valid", bus.out_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_data", bus.out_data, 32'h0);
    chk("t6_rst_cnt", sat_cnt, 16'h0);
    chk("t6_rst_err", cfg_err, 1'b0);
    run_beat("t6_rst_cfg", pin(100, -500, 8160, 8127), pout(2, 0, 127, 127));
    chk("t6_rst_cfg_cnt", sat_cnt, 16'(SE * 2));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lenet_requant.md
Name: lenet_requant

Overview:
- Parametrised, multi-lane requantizer for the LeNet accelerator's FC and conv datapaths.
- Takes LANES wide-accumulator results and applies per-layer runtime config (shift amount, ReLU/signed mode).
- Rounds half-up, arithmetic-shifts and saturates each lane to OUT_W bits.
- Two-stage valid/ready pipeline with backpressure, config latching and saturation statistics; sits between accumulator array and activation buffer.

Parameters:
- IN_W, 23: accumulator lane width (signed).
- OUT_W, 8: quantized lane width (signed).
- LANES, 4: parallel lanes per beat.
- SHIFT_W, 5: width of shift config field.
- RST_SHIFT, 6: shift value loaded at reset.
- RST_RELU, 1: ReLU mode at reset (1 = clamp to [0, 2^(OUT_W-1)-1]).

Ports:
- clk, in, 1: clock.
- srstn, in, 1: synchronous active-low reset.
- cfg_load, in, 1: request to latch cfg_shift/cfg_relu.
- cfg_shift, in, SHIFT_W: right-shift amount, 0..IN_W-1.
- cfg_relu, in, 1: 1 = ReLU clamp, 0 = signed clamp.
- cfg_err, out, 1: sticky; set when cfg_load is rejected.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat.
- in_data, in, LANES*IN_W: lane i at [i*IN_W +: IN_W], signed.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, LANES*OUT_W: lane i at [i*OUT_W +: OUT_W], signed.
- busy, out, 1: any pipeline stage holds valid data.
- sat_clr, in, 1: clear saturation counter.
- sat_cnt, out, 16: count of saturated lanes.

Behaviour:
- Reset (srstn=0 at posedge):
  - out_valid=0, out_data=0, stage-1 valid=0.
  - sat_cnt=0, cfg_err=0.
  - shift=RST_SHIFT, relu=RST_RELU.
- Pipeline:
  - Global enable en = ~out_valid | out_ready; in_ready = en.
  - Beat accepted when in_valid & in_ready.
  - Stage 1 registers rounded/shifted value; stage 2 registers clamped value and drives out_*.
  - Latency: accepted beat appears on out_data 2 cycles later when unstalled.
  - Throughput: 1 beat/cycle.
  - While out_valid & ~out_ready: all stages hold, out_data stable, no beat lost or duplicated; up to 2 beats buffered.
- Arithmetic, per lane, at IN_W+1 bits to avoid overflow:
  - r = x + (shift>0 ? 2^(shift-1) : 0).
  - s = r >>> shift (floor).
  - Clamp bounds: hi = 2^(OUT_W-1)-1; lo = 0 if relu, else -2^(OUT_W-1).
  - out = s>hi ? hi : s<lo ? lo : s[OUT_W-1:0].
  - A lane is saturated when s>hi or s<lo.
- Config:
  - cfg_load is accepted only when busy=0 and in_valid=0; new values apply from the next accepted beat.
  - Otherwise it is ignored, config is unchanged and cfg_err is set (cleared only by reset).
  - cfg_shift >= IN_W is treated as IN_W-1.
- Saturation counter:
  - On each stage-2 load, adds the number of saturated lanes in that beat; saturates at 0xFFFF.
  - sat_clr in the same cycle as an increment: clear wins, result 0.
- busy = stage-1 valid | out_valid.

Optional Feature:
- Macro LENET_REQ_SAT_CNT_EN.
- Defined: saturation detection, counter and sat_clr behave as above.
- Undefined: counter logic removed, sat_cnt tied 0, sat_clr ignored; datapath unaffected.

Decomposition:
- Package lenet_quant_pkg: default widths, mode encodings (MODE_SIGNED=0, MODE_RELU=1), clamp-bound helper functions.
- Sub-module requant_lane: one lane's two pipeline stages with enable. Ports: x, shift, relu, en, srstn, out, sat flag.
- Top instantiates LANES lanes and owns the handshake, config and counter.

Test Plan (IN_W=23, OUT_W=8, LANES=4):
1. Reset config (shift=6, ReLU), lanes {100, -500, 8160, 8127}
   - Expect {2, 0, 127, 127} two cycles after accept.
   - sat_cnt=2.
2. Load shift=5, relu=0, lanes {-4112, -4113, 4079, 4080}
   - Expect {-128, -128, 127, 127}.
   - sat_cnt +2 (lanes 1 and 3).
3. Continuous in_valid, out_ready=0 for 5 cycles
   - in_ready falls after 2 beats.
   - out_data stable throughout.
   - After release, all beats emerge in order with no gaps or duplicates.
4. cfg_load=1 with shift=3 while busy=1
   - cfg_err=1.
   - Next beats still use the prior shift.
5. shift=22, relu=0, lane -4194304
   - Output -1, no overflow.
   - With shift=0, lane 5 passes through as 5.
6. srstn low for 1 cycle mid-stream, and sat_clr coincident with a saturating beat
   - Reset: out_valid=0, sat_cnt=0, shift=6.
   - sat_clr case: sat_cnt=0 next cycle.
